// File: rtl/transceiver_link_fifo_if.sv
// Bundles the user-side FIFO ports and the PMA parallel data ports of the link FIFO.
// Clock and reset stay as plain ports on the module.
interface transceiver_link_fifo_if #(
   parameter int DW    = 16,
   parameter int DEPTH = 512
);
   localparam int LANES = DW / 8;
   localparam int AW    = $clog2(DEPTH);

   logic [DW-1:0]         tx_wr_data;
   logic                  tx_wr_en;
   logic                  pattern_en;
   logic                  tx_full;
   logic [AW:0]           tx_usedw;
   logic [LANES*11-1:0]   tx_parallel_data;
   logic                  tx_std_coreclkin;
   logic                  rx_std_coreclkin;
   logic [LANES*16-1:0]   rx_parallel_data;
   logic                  rx_rd_en;
   logic [DW-1:0]         rx_rd_data;
   logic                  rx_empty;
   logic [AW:0]           rx_usedw;
   logic                  rx_aligned;
   logic [15:0]           rx_overflow_cnt;

   modport master (
      output tx_wr_data, tx_wr_en, pattern_en, rx_parallel_data, rx_rd_en,
      input  tx_full, tx_usedw, tx_parallel_data, tx_std_coreclkin, rx_std_coreclkin,
             rx_rd_data, rx_empty, rx_usedw, rx_aligned, rx_overflow_cnt
   );

   modport slave (
      input  tx_wr_data, tx_wr_en, pattern_en, rx_parallel_data, rx_rd_en,
      output tx_full, tx_usedw, tx_parallel_data, tx_std_coreclkin, rx_std_coreclkin,
             rx_rd_data, rx_empty, rx_usedw, rx_aligned, rx_overflow_cnt
   );
endinterface

// File: rtl/transceiver_link_fifo.sv
// Single-clock transceiver link FIFO: TX FIFO drains onto 8b/10b PMA lanes (idle = K28.5),
// RX side aligns on idle runs and queues all-data words into the RX FIFO.
module transceiver_link_fifo #(
   parameter int DW             = 16,
   parameter int DEPTH          = 512,
   parameter int PATTERN_PERIOD = 5000
) (
   input  logic                  CLK,
   input  logic                  nRST,
   transceiver_link_fifo_if.slave link
);
   localparam int LANES = DW / 8;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = (PATTERN_PERIOD < 1) ? 1 : $clog2(PATTERN_PERIOD + 1);
   localparam logic [7:0] K28_5 = 8'hBC;

   function automatic logic [LANES*11-1:0] tx_lanes(input logic [DW-1:0] w, input logic k);
      logic [LANES*11-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         r[11*i +: 8] = k ? K28_5 : w[8*i +: 8];
         r[11*i + 8]  = k;
      end
      return r;
   endfunction

   // ---------------- TX path ----------------
   logic [DW-1:0]       tx_mem [DEPTH];
   logic [AW-1:0]       tx_wp_q, tx_rp_q;
   logic [AW:0]         tx_used_q, tx_used_d;
   logic [CW-1:0]       pat_q;
   logic [LANES*11-1:0] tx_line_q;
   logic                tx_full, tx_pop, tx_push, tx_src_en;
   logic [DW-1:0]       tx_src;

   assign tx_full   = (tx_used_q == (AW+1)'(DEPTH));
   assign tx_pop    = (tx_used_q != '0);
   assign tx_src_en = link.pattern_en | link.tx_wr_en;
   assign tx_src    = link.pattern_en ? DW'(pat_q) : link.tx_wr_data;
   // A full FIFO is always being drained, so a write alongside that pop is accepted.
   assign tx_push   = tx_src_en && (!tx_full || tx_pop);

   always_comb begin
      tx_used_d = tx_used_q;
      if (tx_push && !tx_pop)
         tx_used_d = tx_used_q + 1'b1;
      else if (tx_pop && !tx_push)
         tx_used_d = tx_used_q - 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (tx_push)
         tx_mem[tx_wp_q] <= tx_src;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         tx_wp_q   <= '0;
         tx_rp_q   <= '0;
         tx_used_q <= '0;
         pat_q     <= '0;
         tx_line_q <= tx_lanes('0, 1'b1);
      end else begin
         if (tx_push)
            tx_wp_q <= tx_wp_q + 1'b1;
         if (tx_pop)
            tx_rp_q <= tx_rp_q + 1'b1;
         tx_used_q <= tx_used_d;
         if (link.pattern_en)
            pat_q <= (pat_q == CW'(PATTERN_PERIOD)) ? '0 : pat_q + 1'b1;
         tx_line_q <= tx_pop ? tx_lanes(tx_mem[tx_rp_q], 1'b0) : tx_lanes('0, 1'b1);
      end
   end

   // ---------------- RX capture and classification ----------------
   typedef enum logic {UNALIGNED, ALIGNED} align_t;

   logic [LANES*9-1:0]  rx_cap_q, rx_cap_d;
   logic [LANES*7-1:0]  rx_unused_bits;
   logic [DW-1:0]       rx_word;
   logic                all_k, no_k, all_bc, is_idle, is_data, is_bad;

   always_comb begin
      rx_cap_d       = '0;
      rx_unused_bits = '0;
      for (int i = 0; i < LANES; i++) begin
         rx_cap_d[9*i +: 9]       = link.rx_parallel_data[16*i +: 9];
         rx_unused_bits[7*i +: 7] = link.rx_parallel_data[16*i+9 +: 7];
      end
   end

   always_comb begin
      all_k   = 1'b1;
      no_k    = 1'b1;
      all_bc  = 1'b1;
      rx_word = '0;
      for (int i = 0; i < LANES; i++) begin
         all_k  = all_k & rx_cap_q[9*i+8];
         no_k   = no_k & ~rx_cap_q[9*i+8];
         all_bc = all_bc & (rx_cap_q[9*i +: 8] == K28_5);
         rx_word[8*i +: 8] = rx_cap_q[9*i +: 8];
      end
   end

   // Mixed datak, or a control character other than K28.5, counts as a link error.
   assign is_idle = all_k & all_bc;
   assign is_data = no_k;
   assign is_bad  = !is_idle && !is_data;

   // ---------------- RX alignment FSM and FIFO ----------------
   align_t              st_q, st_d;
   logic [1:0]          idle_cnt_q, idle_cnt_d;
   logic [DW-1:0]       rx_mem [DEPTH];
   logic [AW-1:0]       rx_wp_q, rx_rp_q;
   logic [AW:0]         rx_used_q, rx_used_d;
   logic [DW-1:0]       rx_rd_data_q;
   logic [15:0]         ovf_q;
   logic                rx_full, rx_empty, rx_pop, rx_push, ovf_inc;

   assign rx_full  = (rx_used_q == (AW+1)'(DEPTH));
   assign rx_empty = (rx_used_q == '0);
   assign rx_pop   = link.rx_rd_en && !rx_empty;

   always_comb begin
      st_d       = st_q;
      idle_cnt_d = idle_cnt_q;
      rx_push    = 1'b0;
      ovf_inc    = 1'b0;
      case (st_q)
         UNALIGNED: begin
            if (is_idle) begin
               if (idle_cnt_q == 2'd3) begin
                  st_d       = ALIGNED;
                  idle_cnt_d = '0;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end else begin
               idle_cnt_d = '0;
            end
         end
         ALIGNED: begin
            if (is_bad) begin
               st_d = UNALIGNED;
            end else if (is_data) begin
               if (!rx_full || rx_pop)
                  rx_push = 1'b1;
               else
                  ovf_inc = 1'b1;
            end
         end
         default: st_d = UNALIGNED;
      endcase
   end

   always_comb begin
      rx_used_d = rx_used_q;
      if (rx_push && !rx_pop)
         rx_used_d = rx_used_q + 1'b1;
      else if (rx_pop && !rx_push)
         rx_used_d = rx_used_q - 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (rx_push)
         rx_mem[rx_wp_q] <= rx_word;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rx_cap_q     <= '0;
         st_q         <= UNALIGNED;
         idle_cnt_q   <= '0;
         rx_wp_q      <= '0;
         rx_rp_q      <= '0;
         rx_used_q    <= '0;
         rx_rd_data_q <= '0;
         ovf_q        <= '0;
      end else begin
         rx_cap_q   <= rx_cap_d;
         st_q       <= st_d;
         idle_cnt_q <= idle_cnt_d;
         if (rx_push)
            rx_wp_q <= rx_wp_q + 1'b1;
         if (rx_pop) begin
            rx_rp_q      <= rx_rp_q + 1'b1;
            rx_rd_data_q <= rx_mem[rx_rp_q];
         end
         rx_used_q <= rx_used_d;
         if (ovf_inc && ovf_q != 16'hFFFF)
            ovf_q <= ovf_q + 1'b1;
      end
   end

   assign link.tx_full          = tx_full;
   assign link.tx_usedw         = tx_used_q;
   assign link.tx_parallel_data = tx_line_q;
   assign link.tx_std_coreclkin = CLK;
   assign link.rx_std_coreclkin = CLK;
   assign link.rx_rd_data       = rx_rd_data_q;
   assign link.rx_empty         = rx_empty;
   assign link.rx_usedw         = rx_used_q;
   assign link.rx_aligned       = (st_q == ALIGNED);
   assign link.rx_overflow_cnt  = ovf_q;
endmodule
